// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad front end of the combination lock.
// Holds the debounce state encoding, the key code width and the key encoders.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } kstate_t;

    localparam int KEY_W = 5;
    localparam logic [KEY_W-1:0] KEY_ENTER = 5'h10;

    // Highest set bit wins, so a stray lower key never masks the intended one.
    function automatic logic [KEY_W-1:0] prio_encode(input logic [31:0] vec);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) begin
                idx = KEY_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic onehot(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/keypad_debounce_sync.sv
// Two-flop synchroniser for the raw push-button bus, cleared by synchronous reset.
module key_sync #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/keypad_debounce.sv
// Synchronises, debounces and priority-encodes the push-buttons into one
// key event per physical press; multi-key presses raise key_err instead.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int NKEYS    = 20,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] pb,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code,
    output logic             key_err,
    output logic             key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [NKEYS-1:0] s;
    logic [NKEYS-1:0] snap_reg;
    logic [31:0]      snap_ext;
    logic [CNT_W-1:0] cnt_reg;
    kstate_t          state_reg;

    key_sync #(.WIDTH(NKEYS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pb),
        .q   (s)
    );

    assign snap_ext = 32'(snap_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            snap_reg  <= '0;
            cnt_reg   <= '0;
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            key_err   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (s != '0) begin
                        snap_reg  <= s;
                        cnt_reg   <= CNT_ONE;
                        state_reg <= DB_PRESS;
                    end
                end
                DB_PRESS: begin
                    if (s == '0) begin
                        state_reg <= IDLE;
                    end else if (s != snap_reg) begin
                        snap_reg <= s;
                        cnt_reg  <= CNT_ONE;
                    end else if (cnt_reg != CNT_LAST) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end else begin
                        // DEBOUNCE-th identical sample: the press is accepted
                        state_reg <= PRESSED;
                        key_held  <= 1'b1;
                        if (onehot(snap_ext)) begin
                            key_valid <= 1'b1;
                            key_code  <= prio_encode(snap_ext);
                        end else begin
                            key_err <= 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (s == '0) begin
                        cnt_reg   <= CNT_ONE;
                        state_reg <= DB_RELEASE;
                    end
                end
                DB_RELEASE: begin
                    if (s != '0) begin
                        state_reg <= PRESSED;
                    end else if (cnt_reg != CNT_LAST) begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end else begin
                        state_reg <= IDLE;
                        key_held  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_debounce.sv
// Randomised and directed bench for keypad_debounce: a run-length reference
// model predicts key events into a scoreboard that a monitor drains.
module tb_keypad_debounce;

    localparam int NKEYS    = 20;
    localparam int DEBOUNCE = 4;

    typedef struct {
        logic       err;
        logic [4:0] code;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NKEYS-1:0] pb  = '0;
    logic             key_valid;
    logic [4:0]       key_code;
    logic             key_err;
    logic             key_held;

    int n_vec  = 0;
    int n_fail = 0;

    ev_t              exp_q[$];
    logic [NKEYS-1:0] hist[$];
    logic             armed  = 1'b0;
    logic             held_m = 1'b0;
    logic [4:0]       code_m = '0;

    always #5 clk = ~clk;

    keypad_debounce #(.NKEYS(NKEYS), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .rst       (rst),
        .pb        (pb),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_err   (key_err),
        .key_held  (key_held)
    );

    function automatic void check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endfunction

    // Reference: a press is accepted after DEBOUNCE consecutive identical
    // nonzero synchronised samples, a release after DEBOUNCE zero samples.
    initial begin : model
        logic [NKEYS-1:0] s_m;
        logic [NKEYS-1:0] snap_m;
        int run;
        int zrun;
        ev_t e;
        snap_m = '0;
        run    = 0;
        zrun   = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                hist.delete();
                exp_q.delete();
                held_m = 1'b0;
                code_m = '0;
                run    = 0;
                zrun   = 0;
                armed  = 1'b1;
            end else begin
                s_m = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
                hist.push_back(pb);
                if (hist.size() > 2) void'(hist.pop_front());
                if (!held_m) begin
                    if (s_m == '0) run = 0;
                    else if (run > 0 && s_m == snap_m) run++;
                    else begin
                        snap_m = s_m;
                        run    = 1;
                    end
                    if (run == DEBOUNCE) begin
                        held_m = 1'b1;
                        zrun   = 0;
                        if ($countones(snap_m) == 1) begin
                            for (int i = 0; i < NKEYS; i++)
                                if (snap_m[i]) code_m = 5'(i);
                            e.err  = 1'b0;
                            e.code = code_m;
                        end else begin
                            e.err  = 1'b1;
                            e.code = code_m;
                        end
                        exp_q.push_back(e);
                    end
                end else begin
                    if (s_m == '0) zrun++;
                    else zrun = 0;
                    if (zrun == DEBOUNCE) begin
                        held_m = 1'b0;
                        run    = 0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (key_valid && key_err) check("valid_and_err", 1, 0);
                if (key_valid || key_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", {30'd0, key_err, key_valid}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_is_err", int'(key_err), int'(e.err));
                        check("event_is_valid", int'(key_valid), int'(!e.err));
                        check("event_code", int'(key_code), int'(e.code));
                    end
                end else if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("missing_event", 0, 1);
                end
                check("key_held", int'(key_held), int'(held_m));
                check("key_code", int'(key_code), int'(code_m));
            end
        end
    end

    task automatic drive(input logic [NKEYS-1:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pb = val;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : stim
        logic [NKEYS-1:0] v;
        logic [NKEYS-1:0] prev;
        int len;
        @(negedge clk);
        rst = 1'b1;
        drive('0, 2);
        rst = 1'b0;
        drive('0, 4);

        // single key, long hold then release
        drive(NKEYS'(1) << 3, 20);
        drive('0, 10);
        // press bounce
        drive(NKEYS'(1) << 7, 1);
        drive('0, 1);
        drive(NKEYS'(1) << 7, 1);
        drive('0, 1);
        drive(NKEYS'(1) << 7, 10);
        drive('0, 10);
        // two keys together
        drive((NKEYS'(1) << 2) | (NKEYS'(1) << 16), 10);
        drive('0, 10);
        // extra key added while held, then enter key
        drive(NKEYS'(1) << 5, 10);
        drive((NKEYS'(1) << 5) | (NKEYS'(1) << 9), 6);
        drive('0, 10);
        drive(NKEYS'(1) << 16, 10);
        drive('0, 10);
        // release bounce
        drive(NKEYS'(1) << 4, 10);
        drive('0, 2);
        drive(NKEYS'(1) << 4, 6);
        drive('0, 10);
        // reset while debouncing a press, key still held afterwards
        drive(NKEYS'(1) << 1, 3);
        rst = 1'b1;
        drive(NKEYS'(1) << 1, 1);
        rst = 1'b0;
        drive(NKEYS'(1) << 1, 12);
        drive('0, 10);

        prev = '0;
        for (int seg = 0; seg < 400; seg++) begin
            case ($urandom_range(0, 5))
                0:       v = '0;
                1, 2:    v = NKEYS'(1) << $urandom_range(0, NKEYS - 1);
                3:       v = (NKEYS'(1) << $urandom_range(0, NKEYS - 1)) |
                             (NKEYS'(1) << $urandom_range(0, NKEYS - 1));
                4:       v = NKEYS'($urandom());
                default: v = prev ^ (NKEYS'(1) << $urandom_range(0, NKEYS - 1));
            endcase
            len = $urandom_range(1, 9);
            drive(v, len);
            prev = v;
            if ($urandom_range(0, 39) == 0) pulse_reset();
        end
        drive('0, 12);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
